// File: rtl/status_frame_tx.sv
// Status frame transmitter: snapshots engine status and streams a framed,
// XOR-checksummed byte sequence through a valid/next pull handshake.
module status_frame_tx #(
  parameter int          data_width      = 16,
  parameter int          spi_fifo_length = 32,
  parameter logic [7:0]  sync_byte       = 8'hA5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               snapshot_req,
  input  logic [7:0]                         control_state,
  input  logic [$clog2(spi_fifo_length):0]   fifo_count,
  input  logic                               current_pipeline,
  input  logic                               invalid_command,
  input  logic [7:0]                         byte_probe,
  input  logic [data_width-1:0]              out_sample,
  input  logic                               sample_tick,
  output logic [7:0]                         tx_byte,
  output logic                               tx_valid,
  input  logic                               tx_next,
  output logic                               busy,
  output logic                               frame_dropped
);

  localparam int FW = $clog2(spi_fifo_length) + 1;
  localparam int SB = data_width / 8;
  localparam int N  = 7 + SB;
  localparam int NB = N + 3;
  localparam int BL = NB - 2;
  localparam int IW = $clog2(NB);
  localparam logic [7:0]    LEN  = 8'(N);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t        state;
  logic [31:0]   cnt;
  logic          sticky;
  logic [IW-1:0] idx;
  logic [IW-1:0] nidx;
  logic [7:0]    fr_q [NB];
  logic [7:0]    body [BL];
  logic [7:0]    csum;
  logic [5:0]    fc6;
  logic          latch;
  logic          take;

  assign latch = (state == IDLE) && snapshot_req;
  assign take  = (state == SEND) && tx_valid && tx_next;
  assign nidx  = idx + 1'b1;

  always_comb begin
    fc6 = '0;
    fc6[FW-1:0] = fifo_count;
  end

  // Payload as it would be captured this cycle (length byte through counter)
  always_comb begin
    for (int i = 0; i < BL; i++) body[i] = '0;
    body[0] = LEN;
    body[1] = control_state;
    body[2] = {current_pipeline, sticky | invalid_command, fc6};
    body[3] = byte_probe;
    for (int i = 0; i < SB; i++)
      body[4+i] = out_sample[data_width-1-8*i -: 8];
    for (int i = 0; i < 4; i++)
      body[4+SB+i] = cnt[31-8*i -: 8];
  end

  always_comb begin
    csum = '0;
    for (int i = 0; i < BL; i++) csum = csum ^ body[i];
  end

  always_ff @(posedge clk) begin
    if (latch && !reset) begin
      fr_q[0] <= sync_byte;
      for (int i = 0; i < BL; i++) fr_q[i+1] <= body[i];
      fr_q[NB-1] <= csum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      sticky        <= 1'b0;
      idx           <= '0;
      tx_byte       <= '0;
      tx_valid      <= 1'b0;
      busy          <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      frame_dropped <= 1'b0;
      cnt           <= cnt + 32'(sample_tick);
      sticky        <= sticky | invalid_command;
      unique case (state)
        IDLE: begin
          if (snapshot_req) begin
            sticky   <= 1'b0;
            busy     <= 1'b1;
            tx_byte  <= sync_byte;
            tx_valid <= 1'b1;
            idx      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (snapshot_req) frame_dropped <= 1'b1;
          if (take) begin
            if (idx == LAST) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= nidx;
              tx_byte <= fr_q[nidx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
